// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: passes non-memory results through and runs loads/stores as one
// req/ack bus transaction each. Optional bus timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_bus_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic { IDLE, BUS_WAIT } state_t;
  typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } size_t;

  state_t      state, state_next;
  logic        is_load, is_store, is_mem, sext, misaligned, aligned_mem;
  size_t       size;
  logic [3:0]  sel;
  logic [31:0] wdata_lanes;
  logic        timeout_hit;

  // Transaction context captured when the request is issued
  logic        op_load, op_wreg, op_sext, op_flushed;
  size_t       op_size;
  logic [1:0]  op_lane;
  logic [4:0]  op_wd;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_W;
    sext     = 1'b0;
    case (aluop_i)
      OP_LB:   begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_B; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_H; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      OP_SW:   begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
  end

  assign is_mem      = is_load | is_store;
  assign misaligned  = is_mem & (((size == SZ_H) & mem_addr_i[0]) |
                                 ((size == SZ_W) & (mem_addr_i[1:0] != 2'b00)));
  assign aligned_mem = is_mem & ~misaligned;

  // Big-endian lanes: sel[3] carries data[31:24], the byte at offset 00
  always_comb begin
    sel         = 4'b1111;
    wdata_lanes = reg2_i;
    case (size)
      SZ_B: begin
        sel         = 4'b1000 >> mem_addr_i[1:0];
        wdata_lanes = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        sel         = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_lanes = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte = bus_rdata_i[31:24];
    case (op_lane)
      2'd1:    rbyte = bus_rdata_i[23:16];
      2'd2:    rbyte = bus_rdata_i[15:8];
      2'd3:    rbyte = bus_rdata_i[7:0];
      default: ;
    endcase
    rhalf = op_lane[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (op_size)
      SZ_B:    load_data = {{24{op_sext & rbyte[7]}}, rbyte};
      SZ_H:    load_data = {{16{op_sext & rhalf[15]}}, rhalf};
      default: load_data = bus_rdata_i;
    endcase
  end

  // Reset gates the stall so it drops together with the asynchronously cleared request
  assign stallreq_o = ~rst & (((state == IDLE) & aligned_mem & ~flush_i) |
                              ((state == BUS_WAIT) & ~bus_ack_i & ~timeout_hit));

  // NOTE: sequential state uses non-blocking assignments with an asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (aligned_mem & ~flush_i) state_next = BUS_WAIT;
      BUS_WAIT: if (bus_ack_i | timeout_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;

  assign timeout_hit = (state == BUS_WAIT) & ~bus_ack_i &
                       (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      bus_err_o <= 1'b0;
    end else begin
      to_cnt    <= (state == BUS_WAIT) ? to_cnt + 1'b1 : '0;
      bus_err_o <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= '0;
      misalign_o  <= 1'b0;
      op_load     <= 1'b0;
      op_wreg     <= 1'b0;
      op_sext     <= 1'b0;
      op_size     <= SZ_W;
      op_lane     <= '0;
      op_wd       <= '0;
      op_flushed  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          op_flushed <= 1'b0;
          if (flush_i) begin
            wb_wreg_o <= 1'b0;
          end else if (misaligned) begin
            wb_wreg_o  <= 1'b0;
            misalign_o <= 1'b1;
          end else if (aligned_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel;
            bus_wdata_o <= wdata_lanes;
            op_load     <= is_load;
            op_wreg     <= wreg_i;
            op_sext     <= sext;
            op_size     <= size;
            op_lane     <= mem_addr_i[1:0];
            op_wd       <= wd_i;
            wb_wreg_o   <= 1'b0;
          end else begin
            wb_wd_o    <= wd_i;
            wb_wreg_o  <= wreg_i;
            wb_wdata_o <= wdata_i;
          end
        end
        BUS_WAIT: begin
          if (bus_ack_i) begin
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= '0;
            wb_wd_o    <= op_wd;
            wb_wreg_o  <= op_load & op_wreg & ~(op_flushed | flush_i);
            wb_wdata_o <= op_load ? load_data : '0;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= '0;
            wb_wreg_o <= 1'b0;
          end else begin
            wb_wreg_o <= 1'b0;
            if (flush_i) op_flushed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Directed bench for mem_bus_stage: single-cycle vector table plus hand-written bus
// transactions, mid-transaction reset and (with MEM_TIMEOUT_EN) a timeout abort.
module tb_mem_bus_stage;

  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        misalign_o;
  logic        bus_err_o;

  mem_bus_stage dut (
    .clk        (clk),
    .rst        (rst),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_sel_o  (bus_sel_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i  (bus_ack_i),
    .wb_wd_o    (wb_wd_o),
    .wb_wreg_o  (wb_wreg_o),
    .wb_wdata_o (wb_wdata_o),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluop_i     = 8'h00;
    wd_i        = '0;
    wreg_i      = 1'b0;
    wdata_i     = '0;
    mem_addr_i  = '0;
    reg2_i      = '0;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
  endtask

  // Single-cycle cases: pass-through, misaligned and flushed instructions
  typedef struct {
    string       name;
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        flush;
    logic        exp_wreg;
    logic        exp_mis;
    logic        chk_data;
  } vec_t;

  vec_t vecs[8];

  // One bus transaction; called at posedge+1 with the stage in IDLE
  task automatic mem_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] st, input int waits, input int flush_at,
                         input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_sel,
                         input logic [31:0] exp_bwdata, input logic exp_wreg,
                         input logic [31:0] exp_wdata);
    int stall_cycles = 0;
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = st;
    wd_i       = 5'd7;
    wreg_i     = 1'b1;
    wdata_i    = 32'h0BAD_0BAD;
    flush_i    = 1'b0;
    #1;
    if (stallreq_o) stall_cycles++;
    check({tag, " idle stall"}, 32'(stallreq_o), 32'd1);
    next_cycle();
    check({tag, " req"}, 32'(bus_req_o), 32'd1);
    check({tag, " addr"}, bus_addr_o, {addr[31:2], 2'b00});
    check({tag, " we"}, 32'(bus_we_o), 32'(exp_we));
    check({tag, " sel"}, 32'(bus_sel_o), 32'(exp_sel));
    if (exp_we) check({tag, " bus wdata"}, bus_wdata_o, exp_bwdata);
    check({tag, " bubble"}, 32'(wb_wreg_o), 32'd0);
    for (int i = 0; i < waits; i++) begin
      if (i == flush_at) flush_i = 1'b1;
      #1;
      if (stallreq_o) stall_cycles++;
      next_cycle();
      flush_i = 1'b0;
      check({tag, " req held"}, 32'(bus_req_o), 32'd1);
      check({tag, " sel held"}, 32'(bus_sel_o), 32'(exp_sel));
      check({tag, " wait bubble"}, 32'(wb_wreg_o), 32'd0);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    if (flush_at == waits) flush_i = 1'b1;
    #1;
    check({tag, " ack stall"}, 32'(stallreq_o), 32'd0);
    next_cycle();
    idle_inputs();
    check({tag, " req drop"}, 32'(bus_req_o), 32'd0);
    check({tag, " wb wreg"}, 32'(wb_wreg_o), 32'(exp_wreg));
    if (exp_wreg) begin
      check({tag, " wb wd"}, 32'(wb_wd_o), 32'd7);
      check({tag, " wb wdata"}, wb_wdata_o, exp_wdata);
    end
    check({tag, " stall cycles"}, 32'(stall_cycles), 32'(waits + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"or pass",    OP_OR,  5'd5,  1'b1, 32'h0000_F0F0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"no wreg",    OP_OR,  5'd31, 1'b0, 32'hFFFF_FFFF, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"lw mis",     OP_LW,  5'd4,  1'b1, 32'h1111_1111, 32'h103,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"add pass",   OP_ADD, 5'd9,  1'b1, 32'h8000_0001, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"lh mis",     OP_LH,  5'd3,  1'b1, 32'h0,         32'h101,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"sw mis",     OP_SW,  5'd0,  1'b0, 32'h0,         32'h202,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"lh flush",   OP_LH,  5'd2,  1'b1, 32'h0,         32'h102,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"add flush",  OP_ADD, 5'd6,  1'b1, 32'h1234_5678, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst req",      32'(bus_req_o),  32'd0);
    check("rst we",       32'(bus_we_o),   32'd0);
    check("rst sel",      32'(bus_sel_o),  32'd0);
    check("rst addr",     bus_addr_o,      32'd0);
    check("rst wb wreg",  32'(wb_wreg_o),  32'd0);
    check("rst wb wd",    32'(wb_wd_o),    32'd0);
    check("rst wb wdata", wb_wdata_o,      32'd0);
    check("rst misalign", 32'(misalign_o), 32'd0);
    check("rst bus err",  32'(bus_err_o),  32'd0);
    check("rst stall",    32'(stallreq_o), 32'd0);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 8; i++) begin
      aluop_i    = vecs[i].aluop;
      wd_i       = vecs[i].wd;
      wreg_i     = vecs[i].wreg;
      wdata_i    = vecs[i].wdata;
      mem_addr_i = vecs[i].addr;
      reg2_i     = 32'hA5A5_A5A5;
      flush_i    = vecs[i].flush;
      #1;
      check({vecs[i].name, " stall"}, 32'(stallreq_o), 32'd0);
      next_cycle();
      check({vecs[i].name, " wb wreg"}, 32'(wb_wreg_o), 32'(vecs[i].exp_wreg));
      check({vecs[i].name, " misalign"}, 32'(misalign_o), 32'(vecs[i].exp_mis));
      check({vecs[i].name, " no req"}, 32'(bus_req_o), 32'd0);
      if (vecs[i].chk_data) begin
        check({vecs[i].name, " wb wd"}, 32'(wb_wd_o), 32'(vecs[i].wd));
        check({vecs[i].name, " wb wdata"}, wb_wdata_o, vecs[i].wdata);
      end
    end
    idle_inputs();
    next_cycle();
    check("misalign pulse end", 32'(misalign_o), 32'd0);

    mem_txn("lb",   OP_LB,  32'h101, 32'h0, 3, -1, 32'h1285_3456, 1'b0, 4'b0100, 32'h0, 1'b1, 32'hFFFF_FF85);
    mem_txn("lhu",  OP_LHU, 32'h102, 32'h0, 1, -1, 32'h1234_8001, 1'b0, 4'b0011, 32'h0, 1'b1, 32'h0000_8001);
    mem_txn("sh",   OP_SH,  32'h200, 32'hDEAD_BEEF, 0, -1, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0);
    mem_txn("sb",   OP_SB,  32'h303, 32'h0000_00A5, 2, -1, 32'h0, 1'b1, 4'b0001, 32'hA5A5_A5A5, 1'b0, 32'h0);
    mem_txn("lw",   OP_LW,  32'h104, 32'h0, 0, -1, 32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFE_BABE);
    mem_txn("lh",   OP_LH,  32'h104, 32'h0, 1, -1, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001);
    mem_txn("lbu",  OP_LBU, 32'h102, 32'h0, 0, -1, 32'h1122_F344, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h0000_00F3);
    mem_txn("lw fl", OP_LW, 32'h010, 32'h0, 2, 0, 32'h0000_0055, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0);
    mem_txn("sw",   OP_SW,  32'h020, 32'h1357_9BDF, 1, -1, 32'h0, 1'b1, 4'b1111, 32'h1357_9BDF, 1'b0, 32'h0);

    // Reset in the middle of a wait: request and stall drop before any clock edge
    aluop_i    = OP_LW;
    mem_addr_i = 32'h400;
    wd_i       = 5'd1;
    wreg_i     = 1'b1;
    next_cycle();
    check("pre-rst req", 32'(bus_req_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async rst req",   32'(bus_req_o),  32'd0);
    check("async rst stall", 32'(stallreq_o), 32'd0);
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    check("post-rst req", 32'(bus_req_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int waited = 0;
      aluop_i    = OP_LW;
      mem_addr_i = 32'h500;
      wd_i       = 5'd2;
      wreg_i     = 1'b1;
      next_cycle();
      for (int i = 1; i <= 40; i++) begin
        next_cycle();
        if (bus_err_o) begin
          waited = i;
          break;
        end
      end
      idle_inputs();
      #1;
      check("timeout wait cycles", 32'(waited), 32'd16);
      check("timeout req drop",    32'(bus_req_o), 32'd0);
      check("timeout wb wreg",     32'(wb_wreg_o), 32'd0);
      check("timeout stall",       32'(stallreq_o), 32'd0);
      next_cycle();
      check("timeout err pulse",   32'(bus_err_o), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
